// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Purpose:
//   Shared definitions for the 5-stage MIPS core:
//     - ALU operation class codes that the main decoder sends to EX.
//     - R-type funct codes that the ALU control decoder understands.
//     - The packed control bundle that travels down the pipeline.
//     - A helper that turns an invalid slot's control into a bubble.
//
// Ports:
//   none (package)
// ---------------------------------------------------------------------------
package mips_pkg;

    // ALU operation classes produced by the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;  // add for lw/sw address
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // sub for beq compare
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // funct field decides

    // R-type funct codes seen on ex_funct
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Decoded control for one instruction slot
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble: no write-back, no memory access, no branch, ALU does an add
    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write  : 1'b0,
        mem_to_reg : 1'b0,
        mem_read   : 1'b0,
        mem_write  : 1'b0,
        branch     : 1'b0,
        alu_src    : 1'b0,
        reg_dst    : 1'b0,
        alu_op     : ALUOP_MEM
    };

    // Keep decoded control only for a real instruction; otherwise hand EX a
    // bubble so a garbage ID slot can never write registers or memory.
    function automatic ctrl_t gateCtrl(input ctrl_t ctrl, input logic valid);
        gateCtrl = valid ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage : mips_pkg

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Purpose:
//   Up-counter that sticks at all-ones instead of wrapping, used to count
//   pipeline flushes for performance debug.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset (clears the count)
//   enable  in   count up by one this cycle
//   count   out  current count, CNT_W bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic atMax;

    // Saturation detect: once every bit is set, further enables are ignored
    // so a long flush storm reads as "at least this many" rather than wrapping.
    assign atMax = (count == CNT_MAX);

    // Count register: reset wins, then increment when enabled and not full
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable && !atMax) begin
            count <= count + CNT_ONE;
        end
    end

endmodule : sat_counter

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// Purpose:
//   ID/EX pipeline register of the 5-stage MIPS core. Captures decoded
//   control, register read data, the sign-extended immediate, PC+4 and the
//   register specifiers from ID and presents them to EX one cycle later.
//   Supports a hazard-unit stall (hold) and a flush (bubble), and counts
//   flushes in a saturating counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold every output this cycle
//   flush                    load a bubble this cycle (beats stall)
//   id_valid                 ID slot holds a real instruction
//   id_reg_write..id_reg_dst decoded control bits
//   id_alu_op [1:0]          ALU operation class
//   id_pc_plus4, id_read_data1, id_read_data2, id_imm   DATA_W datapath
//   id_rs, id_rt, id_rd      register specifiers
//   ex_*                     registered copies of the above for EX
//   ex_funct [5:0]           low six bits of ex_imm, for the ALU decoder
//   flush_count [CNT_W-1:0]  saturating count of flushes since reset
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,

    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [1:0]            id_alu_op,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_read_data1,
    input  logic [DATA_W-1:0]     id_read_data2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,

    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [1:0]            ex_alu_op,
    output logic [5:0]            ex_funct,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_read_data1,
    output logic [DATA_W-1:0]     ex_read_data2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,

    output logic [CNT_W-1:0]      flush_count
);

    ctrl_t                 idCtrl;
    ctrl_t                 loadCtrl;
    ctrl_t                 ctrlQ;
    logic                  validQ;
    logic [DATA_W-1:0]     pcPlus4Q;
    logic [DATA_W-1:0]     readData1Q;
    logic [DATA_W-1:0]     readData2Q;
    logic [DATA_W-1:0]     immQ;
    logic [REG_ADDR_W-1:0] rsQ;
    logic [REG_ADDR_W-1:0] rtQ;
    logic [REG_ADDR_W-1:0] rdQ;

    // Bundle the loose ID control bits so they move as one field, then
    // replace them with a bubble when the ID slot is not a real instruction.
    // Reserved alu_op 2'b11 is carried through untouched.
    always_comb begin
        idCtrl            = CTRL_BUBBLE;
        idCtrl.reg_write  = id_reg_write;
        idCtrl.mem_to_reg = id_mem_to_reg;
        idCtrl.mem_read   = id_mem_read;
        idCtrl.mem_write  = id_mem_write;
        idCtrl.branch     = id_branch;
        idCtrl.alu_src    = id_alu_src;
        idCtrl.reg_dst    = id_reg_dst;
        idCtrl.alu_op     = id_alu_op;
        loadCtrl          = gateCtrl(idCtrl, id_valid);
    end

    // Control and valid: reset and flush both produce a bubble, stall holds,
    // otherwise take the (possibly gated) ID control.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrlQ  <= CTRL_BUBBLE;
            validQ <= 1'b0;
        end else if (!stall) begin
            ctrlQ  <= loadCtrl;
            validQ <= id_valid;
        end
    end

    // Datapath and register specifiers: cleared on reset and flush so a
    // bubble carries no stale operands; loaded regardless of id_valid since
    // the gated control already makes an invalid slot harmless.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pcPlus4Q   <= '0;
            readData1Q <= '0;
            readData2Q <= '0;
            immQ       <= '0;
            rsQ        <= '0;
            rtQ        <= '0;
            rdQ        <= '0;
        end else if (!stall) begin
            pcPlus4Q   <= id_pc_plus4;
            readData1Q <= id_read_data1;
            readData2Q <= id_read_data2;
            immQ       <= id_imm;
            rsQ        <= id_rs;
            rtQ        <= id_rt;
            rdQ        <= id_rd;
        end
    end

    // Flush statistics. The counter applies its own reset first, so a reset
    // coinciding with a flush leaves the count at zero; a stall alone never
    // enables it, so the count naturally holds during stalls.
    sat_counter #(
        .CNT_W (CNT_W)
    ) flushCounter (
        .clk    (clk),
        .rst    (rst),
        .enable (flush),
        .count  (flush_count)
    );

    // Present the registered state to EX. ex_funct is just a view of the
    // immediate's low bits, which is where an R-type funct field lands after
    // sign extension, so the ALU decoder can read it without extra logic.
    assign ex_valid      = validQ;
    assign ex_reg_write  = ctrlQ.reg_write;
    assign ex_mem_to_reg = ctrlQ.mem_to_reg;
    assign ex_mem_read   = ctrlQ.mem_read;
    assign ex_mem_write  = ctrlQ.mem_write;
    assign ex_branch     = ctrlQ.branch;
    assign ex_alu_src    = ctrlQ.alu_src;
    assign ex_reg_dst    = ctrlQ.reg_dst;
    assign ex_alu_op     = ctrlQ.alu_op;
    assign ex_funct      = immQ[5:0];
    assign ex_pc_plus4   = pcPlus4Q;
    assign ex_read_data1 = readData1Q;
    assign ex_read_data2 = readData2Q;
    assign ex_imm        = immQ;
    assign ex_rs         = rsQ;
    assign ex_rt         = rtQ;
    assign ex_rd         = rdQ;

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Purpose:
//   Self-checking bench for id_ex_pipe_reg. A small reference model tracks
//   what EX should see after each clock edge, and each scenario task
//   compares the DUT against it and against hand-derived constants.
//   The DUT is built with CNT_W=4 so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int VEC_W      = 1 + 7 + 2 + 6 + 4 * DATA_W + 3 * REG_ADDR_W + CNT_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic                  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic                  id_branch, id_alu_src, id_reg_dst;
    logic [1:0]            id_alu_op;
    logic [DATA_W-1:0]     id_pc_plus4, id_read_data1, id_read_data2, id_imm;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;

    logic                  ex_valid;
    logic                  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic                  ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0]            ex_alu_op;
    logic [5:0]            ex_funct;
    logic [DATA_W-1:0]     ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic [CNT_W-1:0]      flush_count;

    int errors = 0;
    int checks = 0;

    id_ex_pipe_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_reg_write  (id_reg_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_branch     (id_branch),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_alu_op     (id_alu_op),
        .id_pc_plus4   (id_pc_plus4),
        .id_read_data1 (id_read_data1),
        .id_read_data2 (id_read_data2),
        .id_imm        (id_imm),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_op     (ex_alu_op),
        .ex_funct      (ex_funct),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_read_data1 (ex_read_data1),
        .ex_read_data2 (ex_read_data2),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .flush_count   (flush_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Everything EX sees, flattened into one word for whole-state comparison
    logic [VEC_W-1:0] obsVec;
    assign obsVec = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                     ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_funct,
                     ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm,
                     ex_rs, ex_rt, ex_rd, flush_count};

    // Reference model state: what EX should show after the last edge
    typedef struct packed {
        logic                  valid;
        logic                  regWrite, memToReg, memRead, memWrite, branch, aluSrc, regDst;
        logic [1:0]            aluOp;
        logic [DATA_W-1:0]     pc, rd1, rd2, imm;
        logic [REG_ADDR_W-1:0] rs, rt, rd;
    } model_t;

    model_t model;
    int     modelFlushes;

    function automatic logic [VEC_W-1:0] expectedVec();
        return {model.valid, model.regWrite, model.memToReg, model.memRead, model.memWrite,
                model.branch, model.aluSrc, model.regDst, model.aluOp, model.imm[5:0],
                model.pc, model.rd1, model.rd2, model.imm,
                model.rs, model.rt, model.rd, CNT_W'(modelFlushes)};
    endfunction

    // Rules for one edge: reset clears all, flush makes a bubble and counts
    // (stopping at the counter's maximum), stall keeps everything, otherwise
    // ID is copied with control suppressed for an invalid slot.
    task automatic advanceModel();
        model_t nxt;
        int     nxtFlushes;
        nxt        = model;
        nxtFlushes = modelFlushes;
        if (rst) begin
            nxt        = '0;
            nxtFlushes = 0;
        end else if (flush) begin
            nxt        = '0;
            nxtFlushes = (modelFlushes < CNT_MAX) ? modelFlushes + 1 : CNT_MAX;
        end else if (!stall) begin
            nxt.valid = id_valid;
            nxt.pc    = id_pc_plus4;
            nxt.rd1   = id_read_data1;
            nxt.rd2   = id_read_data2;
            nxt.imm   = id_imm;
            nxt.rs    = id_rs;
            nxt.rt    = id_rt;
            nxt.rd    = id_rd;
            nxt.regWrite = id_valid & id_reg_write;
            nxt.memToReg = id_valid & id_mem_to_reg;
            nxt.memRead  = id_valid & id_mem_read;
            nxt.memWrite = id_valid & id_mem_write;
            nxt.branch   = id_valid & id_branch;
            nxt.aluSrc   = id_valid & id_alu_src;
            nxt.regDst   = id_valid & id_reg_dst;
            nxt.aluOp    = id_valid ? id_alu_op : 2'b00;
        end
        @(posedge clk);
        #1;
        model        = nxt;
        modelFlushes = nxtFlushes;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f);
        rst   = r;
        stall = s;
        flush = f;
    endtask

    task automatic randomizeId();
        id_valid      = 1'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_branch     = 1'($urandom);
        id_alu_src    = 1'($urandom);
        id_reg_dst    = 1'($urandom);
        id_alu_op     = 2'($urandom);
        id_pc_plus4   = $urandom;
        id_read_data1 = $urandom;
        id_read_data2 = $urandom;
        id_imm        = $urandom;
        id_rs         = 5'($urandom);
        id_rt         = 5'($urandom);
        id_rd         = 5'($urandom);
    endtask

    // Two reset cycles with junk on ID must leave EX completely zero
    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            randomizeId();
            advanceModel();
        end
        checks++;
        if (obsVec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0", obsVec);
        end
        checks++;
        if (ex_valid !== 1'b0 || flush_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_valid_count: got valid=%b count=%h expected 0/0",
                     ex_valid, flush_count);
        end
    endtask

    // A valid R-type with funct SLT in the immediate shows up one cycle later
    task automatic test_basic_load();
        applyStimulus(1'b0, 1'b0, 1'b0);
        randomizeId();
        id_valid      = 1'b1;
        id_alu_op     = 2'b10;
        id_imm        = 32'h0000_002A;
        id_read_data1 = 32'h1234_5678;
        id_rd         = 5'd9;
        advanceModel();
        checks++;
        if (ex_alu_op !== 2'b10 || ex_funct !== 6'h2A || ex_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_ctrl: got alu_op=%b funct=%h valid=%b expected 10/2a/1",
                     ex_alu_op, ex_funct, ex_valid);
        end
        checks++;
        if (ex_read_data1 !== 32'h1234_5678 || ex_rd !== 5'd9) begin
            errors++;
            $display("[TB] FAIL basic_data: got rd1=%h rd=%0d expected 12345678/9",
                     ex_read_data1, ex_rd);
        end
        checks++;
        if (obsVec !== expectedVec()) begin
            errors++;
            $display("[TB] FAIL basic_all: got %h expected %h", obsVec, expectedVec());
        end
    endtask

    // A lw held through three stall cycles while ID keeps changing
    task automatic test_stall_hold();
        logic [VEC_W-1:0] held;
        logic [DATA_W-1:0] newImm;
        applyStimulus(1'b0, 1'b0, 1'b0);
        randomizeId();
        id_valid    = 1'b1;
        id_alu_op   = 2'b00;
        id_mem_read = 1'b1;
        advanceModel();
        held = expectedVec();
        checks++;
        if (ex_mem_read !== 1'b1 || ex_alu_op !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stall_lw_load: got mem_read=%b alu_op=%b expected 1/00",
                     ex_mem_read, ex_alu_op);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            randomizeId();
            advanceModel();
            checks++;
            if (obsVec !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, obsVec, held);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        randomizeId();
        newImm = id_imm;
        advanceModel();
        checks++;
        if (obsVec !== expectedVec() || ex_imm !== newImm) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h expected %h", obsVec, expectedVec());
        end
    endtask

    // Flush beats stall on a valid R-type; count goes from 0 to 1
    task automatic test_flush_vs_stall();
        applyStimulus(1'b1, 1'b0, 1'b0);
        randomizeId();
        advanceModel();
        applyStimulus(1'b0, 1'b1, 1'b1);
        randomizeId();
        id_valid     = 1'b1;
        id_alu_op    = 2'b10;
        id_reg_write = 1'b1;
        id_reg_dst   = 1'b1;
        advanceModel();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
             ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL flush_ctrl: got valid=%b rw=%b alu_op=%b expected all 0",
                     ex_valid, ex_reg_write, ex_alu_op);
        end
        checks++;
        if (flush_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL flush_count_one: got %0d expected 1", flush_count);
        end
        checks++;
        if (obsVec !== expectedVec()) begin
            errors++;
            $display("[TB] FAIL flush_all: got %h expected %h", obsVec, expectedVec());
        end
    endtask

    // An invalid slot becomes a bubble but the immediate still loads
    task automatic test_invalid_slot();
        applyStimulus(1'b0, 1'b0, 1'b0);
        randomizeId();
        id_valid     = 1'b0;
        id_reg_write = 1'b1;
        id_mem_write = 1'b1;
        id_alu_op    = 2'b01;
        id_imm       = 32'hDEAD_BEEF;
        advanceModel();
        checks++;
        if (ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_alu_op !== 2'b00 ||
            ex_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_ctrl: got rw=%b mw=%b alu_op=%b valid=%b expected 0/0/00/0",
                     ex_reg_write, ex_mem_write, ex_alu_op, ex_valid);
        end
        checks++;
        if (ex_imm !== 32'hDEAD_BEEF || ex_funct !== 6'h2F) begin
            errors++;
            $display("[TB] FAIL invalid_imm: got imm=%h funct=%h expected deadbeef/2f",
                     ex_imm, ex_funct);
        end
        // Reserved alu_op on a valid slot passes straight through
        randomizeId();
        id_valid  = 1'b1;
        id_alu_op = 2'b11;
        advanceModel();
        checks++;
        if (ex_alu_op !== 2'b11 || obsVec !== expectedVec()) begin
            errors++;
            $display("[TB] FAIL reserved_aluop: got %h expected %h", obsVec, expectedVec());
        end
    endtask

    // Twenty flushes pin the 4-bit counter at F; reset during a flush clears it
    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b1);
            randomizeId();
            advanceModel();
            checks++;
            if (obsVec !== expectedVec()) begin
                errors++;
                $display("[TB] FAIL sat_step_%0d: got count=%h expected %h",
                         i, flush_count, CNT_W'(modelFlushes));
            end
        end
        checks++;
        if (flush_count !== 4'hF) begin
            errors++;
            $display("[TB] FAIL sat_final: got %h expected f", flush_count);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        randomizeId();
        advanceModel();
        checks++;
        if (obsVec !== '0) begin
            errors++;
            $display("[TB] FAIL sat_reset: got %h expected 0", obsVec);
        end
    endtask

    // Random mix of load, stall, flush and occasional reset
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0));
            randomizeId();
            advanceModel();
            checks++;
            if (obsVec !== expectedVec()) begin
                errors++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, obsVec, expectedVec());
            end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        model        = '0;
        modelFlushes = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        randomizeId();
        #2;
        test_reset();
        test_basic_load();
        test_stall_hold();
        test_flush_vs_stall();
        test_invalid_slot();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_id_ex_pipe_reg
